// File: rtl/modulo_contador_t_param_pkg.sv
// Shared constants for the modulo T-flop counters: direction encoding,
// common digit/time-base moduli and a parameter sanity helper.
package modulo_contador_t_param_pkg;

    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

    localparam int unsigned MOD_DIGIT   = 10;
    localparam int unsigned MOD_SEXT    = 6;
    localparam int unsigned MOD_HOURS   = 24;
    localparam int unsigned MOD_MIN_SEC = 60;

    function automatic bit params_ok(input int unsigned width,
                                     input int unsigned modulo,
                                     input int unsigned init_val);
        return (width >= 1) && (width < 32) && (modulo >= 2) &&
               (64'(modulo) <= (64'(1) << width)) && (init_val < modulo);
    endfunction

endpackage

// File: rtl/modulo_contador_t_param_ff_t_celula.sv
// Single T flip-flop cell: toggles on a rising clock edge when t is high,
// asynchronously forced to RST_VAL by clr.
module modulo_ff_t_celula #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic clr,
    input  logic t,
    output logic q
);

    logic q_d, q_q;

    always_comb begin
        q_d = t ? ~q_q : q_q;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/modulo_contador_t_param.sv
// Modulo-M up/down counter on a T flip-flop bank, with parallel load,
// cascade terminal count, registered wrap pulse and sticky load error.
module modulo_contador_t_param
    import modulo_contador_t_param_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MODULO   = MOD_DIGIT,
    parameter int unsigned INIT_VAL = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             load_err
);

    if (!params_ok(WIDTH, MODULO, INIT_VAL)) begin : g_param_err
        $error("modulo_contador_t_param: invalid WIDTH/MODULO/INIT_VAL");
    end

    localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] InitVal = WIDTH'(INIT_VAL);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] toggle;
    logic             load_ok;
    logic             wrap_d, wrap_q;
    logic             load_err_d, load_err_q;

    assign load_ok = (32'(load_val) < MODULO);

    always_comb begin
        count_d    = count;
        wrap_d     = 1'b0;
        load_err_d = load_err_q;
        if (load) begin
            if (load_ok) begin
                count_d = load_val;
            end else begin
                count_d    = MaxVal;
                load_err_d = 1'b1;
            end
        end else if (enable) begin
            if (up_down == CNT_UP) begin
                if (count == MaxVal) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    count_d = MaxVal;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count - WIDTH'(1);
                end
            end
        end
    end

    // Only the bits that differ between current and next value toggle.
    assign toggle = count ^ count_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        modulo_ff_t_celula #(
            .RST_VAL(InitVal[i])
        ) u_cell (
            .clk(clk),
            .clr(clr),
            .t  (toggle[i]),
            .q  (count[i])
        );
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign tc       = enable & ((up_down == CNT_UP) ? (count == MaxVal) : (count == '0));
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule
